// File: rtl/sample_decimator.sv
// Boxcar-averaging decimator: emits one rounded mean per 2^k valid samples (k=0 is a one-register pass-through).
// Optional build macro DECIM_CONVERGENT_EN selects round-half-to-even instead of round-half-up.
module sample_decimator #(
    parameter int MAX_LOG2 = 7,
    parameter int WIDTH    = 12
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             enable,
    input  logic [2:0]       log2_ratio,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    localparam int         ACC_W = WIDTH + MAX_LOG2;
    localparam int         CW    = MAX_LOG2 + 1;
    localparam logic [2:0] K_MAX = 3'(MAX_LOG2);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [MAX_LOG2-1:0] cnt_q, cnt_d;
    logic [2:0]          k_lat_q, k_lat_d;
    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    out_data_q, out_data_d;

    logic                run;
    logic                from_idle;
    logic [2:0]          k_eff;
    logic                cfg_change;
    logic [ACC_W-1:0]    acc_base;
    logic [MAX_LOG2-1:0] cnt_base;
    logic [CW-1:0]       blk_len;
    logic                blk_last;
    logic [ACC_W-1:0]    sum;
    logic [ACC_W-1:0]    half;
    logic [WIDTH-1:0]    mean;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            k_lat_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            k_lat_q     <= k_lat_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d = enable ? ACCUM : IDLE;
    end

    // IDLE still accepts the first sample on the cycle enable rises; it just starts from an empty block.
    always_comb begin
        run       = enable;
        from_idle = (state_q == IDLE);
    end

    always_comb begin
        k_eff      = (log2_ratio > K_MAX) ? K_MAX : log2_ratio;
        cfg_change = (k_eff != k_lat_q);
        acc_base   = (from_idle || cfg_change) ? '0 : acc_q;
        cnt_base   = (from_idle || cfg_change) ? '0 : cnt_q;
        blk_len    = CW'(1) << k_eff;
        blk_last   = ({1'b0, cnt_base} == (blk_len - CW'(1)));
        sum        = acc_base + ACC_W'(in_data);
    end

    // sum never exceeds (2^WIDTH-1)*2^k, so sum+half fits ACC_W and the mean fits WIDTH.
`ifdef DECIM_CONVERGENT_EN
    logic [WIDTH-1:0] quo;
    logic [ACC_W-1:0] rem;

    always_comb begin
        half = '0;
        if (k_eff != 3'd0) begin
            half = ACC_W'(1) << (k_eff - 3'd1);
        end
        quo  = WIDTH'(sum >> k_eff);
        rem  = sum & ((ACC_W'(1) << k_eff) - ACC_W'(1));
        mean = quo;
        if ((k_eff != 3'd0) && ((rem > half) || ((rem == half) && quo[0]))) begin
            mean = quo + WIDTH'(1);
        end
    end
`else
    always_comb begin
        half = '0;
        if (k_eff != 3'd0) begin
            half = ACC_W'(1) << (k_eff - 3'd1);
        end
        mean = WIDTH'((sum + half) >> k_eff);
    end
`endif

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        k_lat_d     = k_eff;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        if (!run) begin
            acc_d = '0;
            cnt_d = '0;
        end else begin
            acc_d = acc_base;
            cnt_d = cnt_base;
            if (in_valid) begin
                if (blk_last) begin
                    out_valid_d = 1'b1;
                    out_data_d  = mean;
                    acc_d       = '0;
                    cnt_d       = '0;
                end else begin
                    acc_d = sum;
                    cnt_d = cnt_base + MAX_LOG2'(1);
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_sample_decimator.sv
// Bench for sample_decimator: vector table plus scoreboard of expected outputs and cycle of arrival.
// A second instance built with MAX_LOG2=5 covers clamping of log2_ratio.
module tb_sample_decimator;

    logic        clk = 1'b0;
    logic        nreset;
    logic        enable;
    logic [2:0]  log2_ratio;
    logic        in_valid;
    logic [11:0] in_data;
    logic        out_valid;
    logic [11:0] out_data;

    logic        en5;
    logic        v5;
    logic [11:0] d5;
    logic        ov5;
    logic [11:0] od5;

    always #5 clk = ~clk;

    sample_decimator #(.MAX_LOG2(7), .WIDTH(12)) u_dut (
        .clk        (clk),
        .nreset     (nreset),
        .enable     (enable),
        .log2_ratio (log2_ratio),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data)
    );

    sample_decimator #(.MAX_LOG2(5), .WIDTH(12)) u_dut5 (
        .clk        (clk),
        .nreset     (nreset),
        .enable     (en5),
        .log2_ratio (3'd7),
        .in_valid   (v5),
        .in_data    (d5),
        .out_valid  (ov5),
        .out_data   (od5)
    );

`ifdef DECIM_CONVERGENT_EN
    localparam logic [11:0] TIE_EXP = 12'd2;
`else
    localparam logic [11:0] TIE_EXP = 12'd3;
`endif

    typedef struct {
        logic        en;
        logic [2:0]  k;
        logic        v;
        logic [11:0] d;
        logic        ev;
        logic [11:0] ed;
    } vec_t;

    typedef struct {
        logic [11:0] d;
        int          cyc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    int          n_vec = 0;
    int          n_miss = 0;
    int          cyc = 0;
    logic        rst_at_edge = 1'b1;
    logic [11:0] exp_hold = 12'd0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    function automatic void add(logic en, logic [2:0] k, logic v, logic [11:0] d, logic ev, logic [11:0] ed);
        vecs.push_back('{en, k, v, d, ev, ed});
    endfunction

    // Called at a negedge: drives one cycle of stimulus and waits for the next negedge.
    task automatic drv(logic en, logic [2:0] k, logic v, logic [11:0] d, logic ev, logic [11:0] ed);
        enable     = en;
        log2_ratio = k;
        in_valid   = v;
        in_data    = d;
        if (ev) begin
            sb.push_back('{ed, cyc + 1});
            $display("drive cyc=%0d en=%0b k=%0d d=%0d -> expect %0d", cyc, en, k, d, ed);
        end
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= !nreset;
    end

    always @(negedge clk) begin
        if (rst_at_edge) begin
            chk("reset_valid", 32'(out_valid), 32'd0);
            chk("reset_data", 32'(out_data), 32'd0);
            exp_hold = 12'd0;
        end else begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                chk("missing_output", 32'd0, 32'(sb[0].d));
                exp_hold = sb[0].d;
                void'(sb.pop_front());
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_output", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    $display("output cyc=%0d data=%0d want=%0d", cyc, out_data, sb[0].d);
                    chk("out_data", 32'(out_data), 32'(sb[0].d));
                    chk("out_latency", 32'(cyc), 32'(sb[0].cyc));
                    exp_hold = sb[0].d;
                    void'(sb.pop_front());
                end
            end else begin
                chk("hold_data", 32'(out_data), 32'(exp_hold));
            end
        end
    end

    initial begin
        nreset     = 1'b0;
        enable     = 1'b0;
        log2_ratio = 3'd0;
        in_valid   = 1'b0;
        in_data    = 12'd0;
        en5        = 1'b0;
        v5         = 1'b0;
        d5         = 12'd0;

        // Pass-through, k=2 means, k=1 ties, k=3
        add(1, 0, 1, 12'h123, 1, 12'h123);
        add(1, 0, 1, 12'hFFF, 1, 12'hFFF);
        add(1, 0, 0, 0, 0, 0);
        add(1, 2, 1, 100, 0, 0);
        add(1, 2, 1, 101, 0, 0);
        add(1, 2, 0, 0, 0, 0);
        add(1, 2, 1, 102, 0, 0);
        add(1, 2, 1, 103, 1, 102);
        add(1, 2, 1, 100, 0, 0);
        add(1, 2, 1, 101, 0, 0);
        add(1, 2, 1, 102, 0, 0);
        add(1, 2, 1, 104, 1, 102);
        add(1, 1, 1, 2, 0, 0);
        add(1, 1, 1, 3, 1, TIE_EXP);
        add(1, 1, 1, 1, 0, 0);
        add(1, 1, 1, 2, 1, 2);
        for (int i = 0; i < 8; i++) add(1, 3, 1, 12'(i), (i == 7), 4);
        // Config change mid-block, then on the would-be completing sample
        for (int i = 0; i < 3; i++) add(1, 2, 1, 10, 0, 0);
        add(1, 1, 1, 20, 0, 0);
        add(1, 1, 1, 22, 1, 21);
        for (int i = 0; i < 3; i++) add(1, 2, 1, 5, 0, 0);
        add(1, 1, 1, 7, 0, 0);
        add(1, 1, 1, 9, 1, 8);
        // Enable falls with the completing sample; samples while disabled are dropped
        for (int i = 0; i < 3; i++) add(1, 2, 1, 50, 0, 0);
        add(0, 2, 1, 50, 0, 0);
        add(0, 2, 1, 77, 0, 0);
        for (int i = 0; i < 4; i++) add(1, 2, 1, 8, (i == 3), 8);
        for (int i = 0; i < 3; i++) add(1, 2, 1, 10, 0, 0);
        add(0, 2, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(1, 2, 1, 8, (i == 3), 8);
        add(1, 2, 0, 0, 0, 0);

        @(negedge clk);
        for (int i = 0; i < 3; i++) drv(1, 0, 1'(i % 2), 12'hABC, 0, 0);
        nreset = 1'b1;
        drv(0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) drv(vecs[i].en, vecs[i].k, vecs[i].v, vecs[i].d, vecs[i].ev, vecs[i].ed);

        // Reset in the middle of a block discards it
        drv(1, 2, 1, 40, 0, 0);
        drv(1, 2, 1, 40, 0, 0);
        nreset = 1'b0;
        drv(1, 2, 1, 40, 0, 0);
        nreset = 1'b1;
        for (int i = 0; i < 4; i++) drv(1, 2, 1, 20, (i == 3), 20);
        drv(1, 2, 0, 0, 0, 0);

        // k=7: 128 full-scale samples with random gaps
        for (int i = 0; i < 128; i++) begin
            drv(1, 7, 1, 12'hFFF, (i == 127), 12'hFFF);
            repeat ($urandom_range(0, 2)) drv(1, 7, 0, 0, 0, 0);
        end
        drv(0, 0, 0, 0, 0, 0);

        // MAX_LOG2=5 build clamps log2_ratio=7 to a 32-sample block; mean of 0,4,..,124 is 62
        for (int i = 0; i < 32; i++) begin
            en5 = 1'b1;
            v5  = 1'b1;
            d5  = 12'(i * 4);
            @(negedge clk);
            chk("clamp_valid", 32'(ov5), 32'(i == 31));
            if (i == 31) begin
                $display("clamp output data=%0d want=62", od5);
                chk("clamp_data", 32'(od5), 32'd62);
            end
        end
        en5 = 1'b0;
        v5  = 1'b0;

        repeat (4) drv(0, 0, 0, 0, 0, 0);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
